// File: rtl/droop_mgr_ml.sv
// Multi-level supply-droop brake/recovery manager: severity-sized fine-code kick
// plus a held divider offset that is stepped back down after the droop clears.
module droop_mgr_ml #(
    parameter int N_LVL        = 4,
    parameter int F_W          = 40,
    parameter int N_W          = 8,
    parameter int CNT_W        = 16,
    parameter int F_PER_LVL    = 1000000,
    parameter int N_PER_LVL    = 3,
    parameter int DIV_STEP     = 1,
    parameter int HOLD_CYCLES  = 32,
    parameter int BRAKE_CYCLES = 500
) (
    input  logic                         refclk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [N_LVL-1:0]             brake,
    output logic [1:0]                   brake_state,
    output logic [$clog2(N_LVL+1)-1:0]   brake_level,
    output logic [F_W-1:0]               delta_f,
    output logic [N_W-1:0]               delta_n,
    output logic [CNT_W-1:0]             events
);

    localparam int LVL_W = $clog2(N_LVL + 1);
    localparam int CD_W  = (BRAKE_CYCLES > 0) ? $clog2(BRAKE_CYCLES + 1) : 1;
    localparam int HD_W  = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    generate
        if (65'(N_LVL) * 65'(N_PER_LVL) >= (65'd1 << N_W)) begin : g_bad_n
            $fatal(1, "droop_mgr_ml: N_LVL*N_PER_LVL does not fit in N_W bits");
        end
        if (65'(N_LVL) * 65'(F_PER_LVL) >= (65'd1 << F_W)) begin : g_bad_f
            $fatal(1, "droop_mgr_ml: N_LVL*F_PER_LVL does not fit in F_W bits");
        end
        if (DIV_STEP < 1) begin : g_bad_step
            $fatal(1, "droop_mgr_ml: DIV_STEP must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BRAKE = 2'd1,
        ST_REC   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    logic [N_W-1:0]     ndelta_q, ndelta_d;
    logic [CD_W-1:0]    cd_q, cd_d;
    logic [HD_W-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0]   events_q, events_d;

    logic [LVL_W-1:0]   sev;
    logic [LVL_W-1:0]   lvl_eff;
    logic [N_W-1:0]     sev_n;
    logic               final_step;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [N_W-1:0] max_n(input logic [N_W-1:0] a, input logic [N_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Highest asserted detector wins; lower bits are irrelevant once a higher one is set.
    always_comb begin
        sev = '0;
        if (en) begin
            for (int i = 0; i < N_LVL; i++) begin
                if (brake[i]) sev = LVL_W'(i + 1);
            end
        end
    end

    assign sev_n      = N_W'(sev) * N_W'(N_PER_LVL);
    assign final_step = (state_q == ST_REC) && (hold_q == '0) && (int'(ndelta_q) <= DIV_STEP);
    // On the edge that would drop to OFF the level is treated as already released.
    assign lvl_eff    = final_step ? '0 : lvl_q;

    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        ndelta_d = ndelta_q;
        cd_d     = cd_q;
        hold_d   = hold_q;
        events_d = events_q;
        unique case (state_q)
            ST_OFF: begin
                if (sev != '0) begin
                    state_d  = ST_BRAKE;
                    lvl_d    = sev;
                    ndelta_d = sev_n;
                    cd_d     = CD_W'(BRAKE_CYCLES);
                    events_d = sat_inc(events_q);
                end
            end
            ST_BRAKE: begin
                if (sev != '0) begin
                    cd_d = CD_W'(BRAKE_CYCLES);
                    if (sev > lvl_q) begin
                        lvl_d    = sev;
                        ndelta_d = max_n(ndelta_q, sev_n);
                    end
                end else if (cd_q != '0) begin
                    cd_d = cd_q - CD_W'(1);
                end else begin
                    state_d = ST_REC;
                    hold_d  = HD_W'(HOLD_CYCLES);
                end
            end
            ST_REC: begin
                if (sev != '0) begin
                    state_d = ST_BRAKE;
                    cd_d    = CD_W'(BRAKE_CYCLES);
                    if (final_step) begin
                        lvl_d    = sev;
                        ndelta_d = sev_n;
                    end else begin
                        lvl_d    = (sev > lvl_q) ? sev : lvl_q;
                        ndelta_d = max_n(ndelta_q, sev_n);
                    end
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HD_W'(1);
                end else if (!final_step) begin
                    ndelta_d = ndelta_q - N_W'(DIV_STEP);
                    hold_d   = HD_W'(HOLD_CYCLES);
                end else begin
                    ndelta_d = '0;
                    lvl_d    = '0;
                    state_d  = ST_OFF;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_OFF;
            lvl_q    <= '0;
            ndelta_q <= '0;
            cd_q     <= '0;
            hold_q   <= '0;
            events_q <= '0;
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            ndelta_q <= ndelta_d;
            cd_q     <= cd_d;
            hold_q   <= hold_d;
            events_q <= events_d;
        end
    end

    assign brake_state = state_q;
    assign brake_level = lvl_q;
    assign delta_n     = max_n(ndelta_q, sev_n);
    assign delta_f     = (sev > lvl_eff) ? F_W'(sev - lvl_eff) * F_W'(F_PER_LVL) : '0;
    assign events      = events_q;

endmodule

// File: doc/droop_mgr_ml.md
Name: droop_mgr_ml

Overview:
- Multi-level supply-droop brake and recovery manager, the parametrised successor to the single-input droop manager.
- Takes N_LVL droop-detector severity inputs and emits two outputs into the DCO/divider path:
  - a one-shot fine-code kick, sized by severity;
  - a held divider offset, sized by severity and stepped back down during recovery.
- Supports escalation while braking and re-braking mid-recovery. Sits between the droop detectors and the frequency accumulator / feedback divider.

Parameters:
- N_LVL, 4, number of severity inputs (bit i = severity i+1).
- F_W, 40, width of delta_f.
- N_W, 8, width of delta_n.
- CNT_W, 16, width of the event counter.
- F_PER_LVL, 1000000, delta_f kick per severity level.
- N_PER_LVL, 3, delta_n offset per severity level.
- DIV_STEP, 1, delta_n decrement per recovery step.
- HOLD_CYCLES, 32, extra ref-cycles held at each recovery step (a step lasts HOLD_CYCLES+1 cycles).
- BRAKE_CYCLES, 500, countdown after all brake inputs deassert.

Ports:
- refclk  in  1  reference clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  brake enable; when 0, the brake inputs are masked. Any in-progress braking/recovery continues.
- brake  in  N_LVL  droop-detector flags; bit i means severity i+1.
- brake_state  out  2  0=OFF, 1=BRAKING, 2=RECOVERING (3 unused).
- brake_level  out  $clog2(N_LVL+1)  currently applied level lvl, 0 when OFF.
- delta_f  out  F_W  fine-code kick, unsigned, nonzero only for the cycle(s) in which level increases.
- delta_n  out  N_W  divider offset, unsigned.
- events  out  CNT_W  saturating count of OFF->BRAKING entries.

Behaviour:
- Reset state: brake_state=OFF, lvl=0, ndelta=0, countdown=0, hold=0, events=0. Hence delta_f=0, delta_n=0.
- sev (combinational): en ? (index of highest set bit of brake)+1 : 0. sev=0 when no bit is set. Lower bits are ignored when a higher bit is set.
- Outputs are combinational, giving zero-latency brake application:
  - delta_f = (sev>lvl) ? (sev-lvl)*F_PER_LVL : 0.
  - delta_n = max(ndelta, sev*N_PER_LVL).
  - brake_state and brake_level come directly from registers.
- OFF:
  - If sev>0: go to BRAKING, lvl<=sev, ndelta<=sev*N_PER_LVL, countdown<=BRAKE_CYCLES, events increments (saturating at all-ones).
- BRAKING:
  - If sev>0: countdown<=BRAKE_CYCLES. If sev>lvl (escalation), lvl<=sev and ndelta<=max(ndelta, sev*N_PER_LVL); the kick is visible combinationally that cycle only.
  - Else if countdown>0: countdown decrements.
  - Else: go to RECOVERING, hold<=HOLD_CYCLES.
- RECOVERING:
  - If sev>0: go to BRAKING, countdown<=BRAKE_CYCLES, ndelta<=max(ndelta, sev*N_PER_LVL). lvl<=max(lvl, sev); delta_f kicks only for the excess over lvl. events does not increment.
  - Else if hold>0: hold decrements.
  - Else if ndelta>DIV_STEP: ndelta<=ndelta-DIV_STEP, hold<=HOLD_CYCLES.
  - Else: ndelta<=0, lvl<=0, state OFF.
- Simultaneous events:
  - sev>0 on the same edge a recovery step would fire: the re-brake wins and no step is taken.
  - sev>0 on the same edge the OFF transition would fire: go to BRAKING instead of OFF. ndelta=sev*N_PER_LVL, kick=sev*F_PER_LVL (because lvl=0 was not yet applied, lvl uses the full sev).
- Never-high cases:
  - Equal or lower severity during BRAKING/RECOVERING never produces a kick and never reduces ndelta.
  - delta_f is never nonzero while sev<=lvl.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous); outputs go to 0 the same instant.
- Elaboration checks: N_LVL*N_PER_LVL < 2**N_W; N_LVL*F_PER_LVL < 2**F_W; DIV_STEP>=1. A violation is a fatal error.

Test Plan:
(Parameters for all scenarios: N_LVL=4, F_PER_LVL=1000, N_PER_LVL=3, DIV_STEP=2, HOLD_CYCLES=2, BRAKE_CYCLES=4. Edge E0 is the first edge with the stimulus present.)
- Single level-1 pulse (brake=0001 for one cycle at E0):
  - That cycle: delta_f=1000, delta_n=3.
  - State BRAKING after E0; RECOVERING after E5.
  - delta_n=1 after E8; OFF with delta_n=0 and brake_level=0 after E11.
  - events=1.
- Escalation: brake=0001 at E0, then 0100 at E2 (held to E3):
  - delta_f=1000 in the E0 cycle, 2000 in the E2 cycle, 0 otherwise.
  - delta_n=9 from E2; brake_level=3.
- Re-brake mid-recovery: level-2 pulse, then brake=0001 at E7 while in RECOVERING with ndelta=6:
  - Returns to BRAKING; delta_f=0; delta_n stays 6.
  - countdown reloaded to 4; events stays 1.
- Masking: en=0 with brake=1111 for 10 cycles -> state OFF, delta_f=0, delta_n=0, events=0.
- Re-brake vs. final step: brake=0010 on the exact edge recovery would go OFF -> state BRAKING, delta_n=6, delta_f=2000.
- Reset mid-BRAKING: assert reset with lvl=3 -> brake_state=0, delta_n=0, events=0 without waiting for an edge. After release with brake=0, the block stays OFF.
